// File: rtl/can_ctrl_pkg.sv
// Shared types and widths for the CAN transmit path.
package can_ctrl_pkg;

  localparam int unsigned CAN_ID_W   = 11;
  localparam int unsigned CAN_DLC_W  = 4;
  localparam int unsigned CAN_DATA_W = 64;
  localparam int unsigned OWNER_W    = 3;
  localparam int unsigned RETRY_W    = 4;

  typedef struct packed {
    logic [CAN_ID_W-1:0]   id;
    logic [CAN_DLC_W-1:0]  dlc;
    logic [CAN_DATA_W-1:0] data;
  } can_frame_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/can_prio_select.sv
// Combinational finder of the valid requester with the lowest CAN id;
// ties go to the lowest index, mirroring bus arbitration.
module can_prio_select
  import can_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*CAN_ID_W-1:0] req_id,
  output logic [OWNER_W-1:0]          winner_idx,
  output logic                        any_valid
);

  logic [CAN_ID_W-1:0] best_id;
  logic                found;

  always_comb begin
    winner_idx = '0;
    best_id    = '1;
    found      = 1'b0;
    // Strict less-than keeps the earlier (lower) index on equal ids.
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && (!found || (req_id[i*CAN_ID_W +: CAN_ID_W] < best_id))) begin
        winner_idx = OWNER_W'(i);
        best_id    = req_id[i*CAN_ID_W +: CAN_ID_W];
        found      = 1'b1;
      end
    end
  end

  assign any_valid = |req_valid;

endmodule

// File: rtl/can_tx_scheduler.sv
// Shares one CAN frame transmitter between NUM_REQ requesters: lowest-id
// selection, start/wait sequencing, per-requester retry and result pulses.
module can_tx_scheduler
  import can_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned MAX_RETRIES    = 8,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic                            can_clk,
  input  logic                            can_rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*CAN_ID_W-1:0]     req_id,
  input  logic [NUM_REQ*CAN_DLC_W-1:0]    req_dlc,
  input  logic [NUM_REQ*CAN_DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              req_fail,
  output logic                            tx_start,
  output logic [CAN_ID_W-1:0]             tx_id,
  output logic [CAN_DLC_W-1:0]            tx_dlc,
  output logic [CAN_DATA_W-1:0]           tx_data,
  input  logic                            tx_busy,
  input  logic                            tx_done,
  input  logic                            tx_arb_lost,
  input  logic                            tx_error,
  output logic                            sched_busy,
  output logic [OWNER_W-1:0]              owner
);

  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  sched_state_t                      state_q, state_d;
  can_frame_t                        frame_q, frame_d, sel_frame;
  logic [OWNER_W-1:0]                owner_q, owner_d;
  logic                              start_q, start_d;
  logic                              busy_q, busy_d;
  logic [NUM_REQ-1:0]                ready_q, ready_d;
  logic [NUM_REQ-1:0]                fail_q, fail_d;
  logic [TMO_W-1:0]                  tmo_q, tmo_d;
  logic [NUM_REQ-1:0][RETRY_W-1:0]   retry_q, retry_d;

  logic [OWNER_W-1:0]                winner_idx;
  logic                              any_valid;
  logic [NUM_REQ-1:0]                owner_oh;
  logic [RETRY_W-1:0]                cur_retry, retry_next, retry_wval;
  logic                              retry_wr;
  logic                              grant_ok;

  can_prio_select #(.NUM_REQ(NUM_REQ)) u_prio (
    .req_valid  (req_valid),
    .req_id     (req_id),
    .winner_idx (winner_idx),
    .any_valid  (any_valid)
  );

  // Winner's frame fields, picked from the flat request buses.
  always_comb begin
    sel_frame = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (winner_idx == OWNER_W'(i)) begin
        sel_frame.id   = req_id[i*CAN_ID_W +: CAN_ID_W];
        sel_frame.dlc  = req_dlc[i*CAN_DLC_W +: CAN_DLC_W];
        sel_frame.data = req_data[i*CAN_DATA_W +: CAN_DATA_W];
      end
    end
  end

  always_comb begin
    cur_retry = '0;
    owner_oh  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner_q == OWNER_W'(i)) begin
        cur_retry   = retry_q[i];
        owner_oh[i] = 1'b1;
      end
    end
  end

  assign retry_next = cur_retry + RETRY_W'(1);
  // Hold off selection while a result pulse is out so the finished requester can drop valid.
  assign grant_ok   = ((ready_q | fail_q) == '0);

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    owner_d    = owner_q;
    start_d    = 1'b0;
    ready_d    = '0;
    fail_d     = '0;
    tmo_d      = tmo_q;
    retry_d    = retry_q;
    retry_wr   = 1'b0;
    retry_wval = '0;

    case (state_q)
      IDLE: begin
        if (any_valid && !tx_busy && grant_ok) begin
          frame_d = sel_frame;
          owner_d = winner_idx;
          start_d = 1'b1;
          state_d = START;
        end
      end
      START: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (tmo_q != TMO_LAST) begin
          tmo_d = tmo_q + TMO_W'(1);
        end
        if (tx_done) begin
          ready_d    = owner_oh;
          retry_wr   = 1'b1;
          retry_wval = '0;
          state_d    = IDLE;
        end else if (tx_arb_lost) begin
          state_d = IDLE;
        end else if (tx_error || (tmo_q == TMO_LAST)) begin
          retry_wr = 1'b1;
          if (retry_next == RETRY_MAX) begin
            fail_d     = owner_oh;
            retry_wval = '0;
          end else begin
            retry_wval = retry_next;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (retry_wr && owner_oh[i]) begin
        retry_d[i] = retry_wval;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge can_clk or negedge can_rst_n) begin
    if (!can_rst_n) begin
      state_q <= IDLE;
      frame_q <= '0;
      owner_q <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= '0;
      fail_q  <= '0;
      tmo_q   <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      owner_q <= owner_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      fail_q  <= fail_d;
      tmo_q   <= tmo_d;
      retry_q <= retry_d;
    end
  end

  assign req_ready  = ready_q;
  assign req_fail   = fail_q;
  assign tx_start   = start_q;
  assign tx_id      = frame_q.id;
  assign tx_dlc     = frame_q.dlc;
  assign tx_data    = frame_q.data;
  assign sched_busy = busy_q;
  assign owner      = owner_q;

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// transaction-level priority/retry model.
module tb_can_tx_scheduler;
  import can_ctrl_pkg::*;

  localparam int unsigned N    = 4;
  localparam int unsigned MAXR = 3;
  localparam int unsigned TMO  = 64;
  localparam int OUT_DONE = 0, OUT_ARB = 1, OUT_ERR = 2, OUT_TMO = 3, OUT_DONE_ERR = 4;

  logic                        can_clk = 1'b0;
  logic                        can_rst_n;
  logic [N-1:0]                req_valid, req_ready, req_fail;
  logic [N*CAN_ID_W-1:0]       req_id;
  logic [N*CAN_DLC_W-1:0]      req_dlc;
  logic [N*CAN_DATA_W-1:0]     req_data;
  logic                        tx_start, tx_busy, tx_done, tx_arb_lost, tx_error, sched_busy;
  logic [CAN_ID_W-1:0]         tx_id;
  logic [CAN_DLC_W-1:0]        tx_dlc;
  logic [CAN_DATA_W-1:0]       tx_data;
  logic [2:0]                  owner;

  logic [N-1:0]                r_v;
  logic [CAN_ID_W-1:0]         r_id   [N];
  logic [CAN_DLC_W-1:0]        r_dlc  [N];
  logic [CAN_DATA_W-1:0]       r_data [N];
  int                          model_retry [N];
  int                          n_cmp = 0;
  int                          n_bad = 0;

  always #5 can_clk = ~can_clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_id[i*CAN_ID_W +: CAN_ID_W]       = r_id[i];
      req_dlc[i*CAN_DLC_W +: CAN_DLC_W]    = r_dlc[i];
      req_data[i*CAN_DATA_W +: CAN_DATA_W] = r_data[i];
    end
  end
  assign req_valid = r_v;

  can_tx_scheduler #(.NUM_REQ(N), .MAX_RETRIES(MAXR), .TIMEOUT_CYCLES(TMO)) dut (
    .can_clk(can_clk), .can_rst_n(can_rst_n),
    .req_valid(req_valid), .req_id(req_id), .req_dlc(req_dlc), .req_data(req_data),
    .req_ready(req_ready), .req_fail(req_fail),
    .tx_start(tx_start), .tx_id(tx_id), .tx_dlc(tx_dlc), .tx_data(tx_data),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_arb_lost(tx_arb_lost), .tx_error(tx_error),
    .sched_busy(sched_busy), .owner(owner)
  );

  task automatic set_req(input int i, input logic [10:0] id);
    r_v[i]    = 1'b1;
    r_id[i]   = id;
    r_dlc[i]  = 4'($urandom_range(0, 8));
    r_data[i] = {$urandom, $urandom};
  endtask

  // Model winner: minimise the composite key (id, index).
  function automatic int exp_winner();
    int best_key = -1;
    int best     = -1;
    for (int i = 0; i < N; i++) begin
      if (r_v[i]) begin
        int key = int'(r_id[i]) * 8 + i;
        if (best_key < 0 || key < best_key) begin
          best_key = key;
          best     = i;
        end
      end
    end
    return best;
  endfunction

  task automatic wait_start(output int cycles);
    cycles = -1;
    for (int c = 1; c <= 4 * TMO; c++) begin
      @(negedge can_clk);
      if (tx_start === 1'b1) begin
        cycles = c;
        break;
      end
    end
  endtask

  task automatic finish(input int outcome, input int dly,
                        output logic [N-1:0] rdy, output logic [N-1:0] fl, output int waited);
    waited = 0;
    if (outcome == OUT_TMO) begin
      while (sched_busy === 1'b1 && waited < 4 * TMO) begin
        @(negedge can_clk);
        waited++;
      end
    end else begin
      repeat (dly) @(negedge can_clk);
      tx_done     = (outcome == OUT_DONE) || (outcome == OUT_DONE_ERR);
      tx_arb_lost = (outcome == OUT_ARB);
      tx_error    = (outcome == OUT_ERR) || (outcome == OUT_DONE_ERR);
      @(negedge can_clk);
      tx_done = 1'b0; tx_arb_lost = 1'b0; tx_error = 1'b0;
    end
    rdy = req_ready;
    fl  = req_fail;
  endtask

  task automatic test_reset();
    @(negedge can_clk);
    n_cmp++;
    if ({req_ready, req_fail, tx_start, sched_busy, owner, tx_id, tx_dlc} !== '0 || tx_data !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: rdy=%b fail=%b start=%b busy=%b owner=%0d id=%h want all 0",
               req_ready, req_fail, tx_start, sched_busy, owner, tx_id);
    end
    can_rst_n = 1'b1;
    repeat (2) @(negedge can_clk);
    n_cmp++;
    if (sched_busy !== 1'b0 || tx_start !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: busy=%b start=%b want 0 0", sched_busy, tx_start);
    end
  endtask

  task automatic test_single();
    int cyc, w;
    logic [N-1:0] rdy, fl;
    set_req(0, 11'h123);
    r_dlc[0]  = 4'd8;
    r_data[0] = 64'h0807060504030201;
    wait_start(cyc);
    n_cmp++;
    if (cyc != 1 || owner !== 3'd0) begin
      n_bad++; $display("FAIL single_start: latency=%0d owner=%0d want 1 0", cyc, owner);
    end
    n_cmp++;
    if (tx_id !== 11'h123 || tx_dlc !== 4'd8 || tx_data !== 64'h0807060504030201) begin
      n_bad++; $display("FAIL single_frame: id=%h dlc=%h data=%h want 123 8 0807060504030201", tx_id, tx_dlc, tx_data);
    end
    @(negedge can_clk);
    n_cmp++;
    if (tx_start !== 1'b0 || sched_busy !== 1'b1) begin
      n_bad++; $display("FAIL single_pulse_width: start=%b busy=%b want 0 1", tx_start, sched_busy);
    end
    finish(OUT_DONE, 49, rdy, fl, w);
    n_cmp++;
    if (rdy !== 4'b0001 || fl !== 4'b0000) begin
      n_bad++; $display("FAIL single_result: ready=%b fail=%b want 0001 0000", rdy, fl);
    end
    r_v[0] = 1'b0;
    @(negedge can_clk);
    n_cmp++;
    if (req_ready !== '0 || sched_busy !== 1'b0 || tx_id !== 11'h123) begin
      n_bad++; $display("FAIL single_after: ready=%b busy=%b id=%h want 0000 0 123", req_ready, sched_busy, tx_id);
    end
  endtask

  task automatic test_priority();
    int cyc, w;
    logic [N-1:0] rdy, fl;
    int exp_order [4] = '{2, 0, 1, 3};
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) begin set_req(0, 11'h200); set_req(2, 11'h100); end
      else begin set_req(1, 11'h050); set_req(3, 11'h050); end
      for (int k = 0; k < 2; k++) begin
        int e = exp_order[pass*2 + k];
        wait_start(cyc);
        n_cmp++;
        if (int'(owner) != e || tx_id !== r_id[e] || (k == 1 && cyc != 2)) begin
          n_bad++; $display("FAIL priority_owner: owner=%0d id=%h latency=%0d want %0d %h", owner, tx_id, cyc, e, r_id[e]);
        end
        finish(OUT_DONE, 3, rdy, fl, w);
        n_cmp++;
        if (rdy !== 4'(1 << e) || fl !== '0) begin
          n_bad++; $display("FAIL priority_result: ready=%b fail=%b want %b 0000", rdy, fl, 4'(1 << e));
        end
        r_v[e] = 1'b0;
      end
    end
  endtask

  task automatic test_arb_lost();
    int cyc, w;
    logic [N-1:0] rdy, fl;
    set_req(0, 11'h300);
    wait_start(cyc);
    set_req(1, 11'h010);
    finish(OUT_ARB, 3, rdy, fl, w);
    n_cmp++;
    if (rdy !== '0 || fl !== '0) begin
      n_bad++; $display("FAIL arb_no_pulse: ready=%b fail=%b want 0000 0000", rdy, fl);
    end
    wait_start(cyc);
    n_cmp++;
    if (owner !== 3'd1 || cyc != 1) begin
      n_bad++; $display("FAIL arb_reselect: owner=%0d latency=%0d want 1 1", owner, cyc);
    end
    finish(OUT_DONE, 2, rdy, fl, w);
    r_v[1] = 1'b0;
    // Arbitration loss must not consume a retry: the fail lands on the third error exactly.
    for (int k = 1; k <= MAXR; k++) begin
      wait_start(cyc);
      n_cmp++;
      if (owner !== 3'd0 || tx_id !== 11'h300) begin
        n_bad++; $display("FAIL arb_retx_owner: owner=%0d id=%h want 0 300", owner, tx_id);
      end
      finish(OUT_ERR, 2, rdy, fl, w);
      n_cmp++;
      if (rdy !== '0 || fl !== ((k == MAXR) ? 4'b0001 : 4'b0000)) begin
        n_bad++; $display("FAIL arb_retry_%0d: ready=%b fail=%b want 0000 %b", k, rdy, fl, (k == MAXR) ? 4'b0001 : 4'b0000);
      end
    end
    r_v[0] = 1'b0;
  endtask

  task automatic test_timeout();
    int cyc, w;
    logic [N-1:0] rdy, fl;
    set_req(2, 11'h7FF);
    for (int k = 1; k <= MAXR; k++) begin
      wait_start(cyc);
      finish(OUT_TMO, 0, rdy, fl, w);
      n_cmp++;
      if (cyc < 0 || w != TMO + 1 || rdy !== '0 || fl !== ((k == MAXR) ? 4'b0100 : 4'b0000)) begin
        n_bad++; $display("FAIL timeout_%0d: waited=%0d ready=%b fail=%b want %0d 0000 %b",
                          k, w, rdy, fl, TMO + 1, (k == MAXR) ? 4'b0100 : 4'b0000);
      end
    end
    r_v[2] = 1'b0;
  endtask

  task automatic test_done_err_busy_drop();
    int cyc, w, stray;
    logic [N-1:0] rdy, fl;
    set_req(2, 11'h055);
    wait_start(cyc);
    finish(OUT_DONE_ERR, 3, rdy, fl, w);
    n_cmp++;
    if (rdy !== 4'b0100 || fl !== '0) begin
      n_bad++; $display("FAIL done_and_error: ready=%b fail=%b want 0100 0000", rdy, fl);
    end
    r_v[2] = 1'b0;
    tx_busy = 1'b1;
    set_req(1, 11'h066);
    stray = 0;
    repeat (5) begin
      @(negedge can_clk);
      if (tx_start !== 1'b0 || sched_busy !== 1'b0) stray++;
    end
    n_cmp++;
    if (stray != 0) begin
      n_bad++; $display("FAIL busy_hold: starts_or_busy=%0d want 0", stray);
    end
    tx_busy = 1'b0;
    wait_start(cyc);
    n_cmp++;
    if (cyc != 1 || owner !== 3'd1) begin
      n_bad++; $display("FAIL busy_release: latency=%0d owner=%0d want 1 1", cyc, owner);
    end
    r_v[1] = 1'b0;
    finish(OUT_DONE, 2, rdy, fl, w);
    n_cmp++;
    if (rdy !== 4'b0010 || fl !== '0) begin
      n_bad++; $display("FAIL drop_valid_result: ready=%b fail=%b want 0010 0000", rdy, fl);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, w;
    logic [N-1:0] rdy, fl;
    set_req(0, 11'h0AA);
    wait_start(cyc);
    finish(OUT_ERR, 2, rdy, fl, w);
    wait_start(cyc);
    repeat (3) @(negedge can_clk);
    can_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready, req_fail, tx_start, sched_busy, owner, tx_id, tx_dlc} !== '0 || tx_data !== '0) begin
      n_bad++; $display("FAIL reset_mid_outputs: rdy=%b fail=%b start=%b busy=%b id=%h want all 0",
                        req_ready, req_fail, tx_start, sched_busy, tx_id);
    end
    for (int i = 0; i < N; i++) model_retry[i] = 0;
    repeat (2) @(negedge can_clk);
    can_rst_n = 1'b1;
    for (int k = 1; k <= MAXR; k++) begin
      wait_start(cyc);
      n_cmp++;
      if (owner !== 3'd0 || (k == 1 && cyc != 1)) begin
        n_bad++; $display("FAIL reset_restart_%0d: owner=%0d latency=%0d want 0", k, owner, cyc);
      end
      finish(OUT_ERR, 1, rdy, fl, w);
      n_cmp++;
      if (rdy !== '0 || fl !== ((k == MAXR) ? 4'b0001 : 4'b0000)) begin
        n_bad++; $display("FAIL reset_retry_%0d: ready=%b fail=%b want 0000 %b", k, rdy, fl, (k == MAXR) ? 4'b0001 : 4'b0000);
      end
    end
    r_v[0] = 1'b0;
  endtask

  task automatic test_random();
    int cyc, w, e, oc, r;
    logic [N-1:0] rdy, fl, er, ef;
    for (int it = 0; it < 200; it++) begin
      if (it >= 40 && r_v == '0) break;
      if (it < 40) begin
        for (int i = 0; i < N; i++)
          if (!r_v[i] && $urandom_range(0, 1) == 1) set_req(i, 11'($urandom_range(0, 15)));
        if (r_v == '0) set_req($urandom_range(0, N - 1), 11'($urandom_range(0, 15)));
      end
      e = exp_winner();
      wait_start(cyc);
      n_cmp++;
      if (cyc < 0 || int'(owner) != e) begin
        n_bad++; $display("FAIL rand_owner it=%0d: owner=%0d latency=%0d want %0d", it, owner, cyc, e);
      end
      n_cmp++;
      if (tx_id !== r_id[e] || tx_dlc !== r_dlc[e] || tx_data !== r_data[e]) begin
        n_bad++; $display("FAIL rand_frame it=%0d: id=%h dlc=%h data=%h want %h %h %h",
                          it, tx_id, tx_dlc, tx_data, r_id[e], r_dlc[e], r_data[e]);
      end
      r = $urandom_range(0, 9);
      oc = (it >= 40 || r < 4) ? OUT_DONE : (r < 6) ? OUT_ARB : (r < 9) ? OUT_ERR : OUT_TMO;
      finish(oc, $urandom_range(1, 6), rdy, fl, w);
      er = '0;
      ef = '0;
      if (oc == OUT_DONE) begin
        er[e] = 1'b1;
        model_retry[e] = 0;
      end else if (oc == OUT_ERR || oc == OUT_TMO) begin
        model_retry[e]++;
        if (model_retry[e] == MAXR) begin
          ef[e] = 1'b1;
          model_retry[e] = 0;
        end
      end
      n_cmp++;
      if (rdy !== er || fl !== ef) begin
        n_bad++; $display("FAIL rand_result it=%0d oc=%0d: ready=%b fail=%b want %b %b", it, oc, rdy, fl, er, ef);
      end
      r_v = r_v & ~(er | ef);
    end
  endtask

  initial begin
    can_rst_n = 1'b1;
    r_v = '0; tx_busy = 1'b0; tx_done = 1'b0; tx_arb_lost = 1'b0; tx_error = 1'b0;
    for (int i = 0; i < N; i++) begin
      r_id[i] = '0; r_dlc[i] = '0; r_data[i] = '0; model_retry[i] = 0;
    end
    #2 can_rst_n = 1'b0;
    test_reset();
    test_single();
    test_priority();
    test_arb_lost();
    test_timeout();
    test_done_err_busy_drop();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
